// File: rtl/fm_pkg.sv
// Shared types and default widths for the FM phase-increment path.
// FM_HOLD_CYC is the same hold interval the CDC documentation assumes.
package fm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    OUT,
    HOLD
  } fm_state_e;

  localparam int FM_SW       = 8;
  localparam int FM_KW       = 8;
  localparam int FM_DW       = 24;
  localparam int FM_HOLD_CYC = 4;

endpackage

// File: rtl/fm_inc_word_gen_if.sv
// Sample handshake and phase-increment output bundle.
// master = sample source / CDC side, slave = fm_inc_word_gen.
interface fm_inc_word_gen_if
  import fm_pkg::*;
#(
  parameter int SW = FM_SW,
  parameter int DW = FM_DW
);

  logic signed [SW-1:0] smp_data;
  logic                 smp_valid;
  logic                 smp_ready;
  logic [DW-1:0]        out_data;
  logic                 out_dv;

  modport master (
    output smp_data,
    output smp_valid,
    input  smp_ready,
    input  out_data,
    input  out_dv
  );

  modport slave (
    input  smp_data,
    input  smp_valid,
    output smp_ready,
    output out_data,
    output out_dv
  );

endinterface

// File: rtl/fm_smul_shift_add.sv
// Serial signed x unsigned shift-add multiplier, one gain bit per cycle.
// start loads operands; done is high on the cycle the last bit is added.
module fm_smul_shift_add
  import fm_pkg::*;
#(
  parameter int SW = FM_SW,
  parameter int KW = FM_KW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    start,
  input  logic signed [SW-1:0]    a,
  input  logic [KW-1:0]           b,
  output logic                    done,
  output logic signed [SW+KW-1:0] product
);

  localparam int PW = SW + KW;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [CW-1:0] LAST = CW'(KW - 1);

  logic                 run_q, run_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [SW-1:0] a_q, a_d;
  logic [KW-1:0]        b_q, b_d;
  logic signed [PW-1:0] acc_q, acc_d;
  logic signed [PW-1:0] term;

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    term  = PW'(a_q) << cnt_q;
    if (ena) begin
      if (start) begin
        run_d = 1'b1;
        cnt_d = '0;
        a_d   = a;
        b_d   = b;
        acc_d = '0;
      end else if (run_q) begin
        if (b_q[cnt_q]) acc_d = acc_q + term;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign done    = ena & run_q & (cnt_q == LAST);
  assign product = acc_q;

endmodule

// File: rtl/fm_inc_word_gen.sv
// Phase increment generator: base_inc + sample*dev_gain, dv pulse, then hold.
// SATURATE_EN clamps the sum to 0..2^DW-1 instead of wrapping.
module fm_inc_word_gen
  import fm_pkg::*;
#(
  parameter int SW       = FM_SW,
  parameter int KW       = FM_KW,
  parameter int DW       = FM_DW,
  parameter int HOLD_CYC = FM_HOLD_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [DW-1:0]    base_inc,
  input  logic [KW-1:0]    dev_gain,
  fm_inc_word_gen_if.slave bus,
  output logic             busy
);

  localparam int PW = SW + KW;
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYC - 1);

  fm_state_e     state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [DW-1:0] base_q, base_d;
  logic [DW-1:0] data_q, data_d;
  logic          dv_q, dv_d;
  logic          rdy_q, rdy_d;
  logic          start;
  logic          mul_done;
  logic signed [PW-1:0] prod;
  logic [DW-1:0] res;

  fm_smul_shift_add #(
    .SW (SW),
    .KW (KW)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (start),
    .a       (bus.smp_data),
    .b       (dev_gain),
    .done    (mul_done),
    .product (prod)
  );

`ifdef SATURATE_EN
  // Two spare bits: base can reach 2^DW-1 before the product is added.
  logic signed [DW+1:0] sum;
  assign sum = signed'({2'b00, base_q}) + (DW+2)'(prod);
  always_comb begin
    if (sum[DW+1])   res = '0;
    else if (sum[DW]) res = '1;
    else             res = sum[DW-1:0];
  end
`else
  assign res = base_q + DW'(prod);
`endif

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    base_d  = base_q;
    data_d  = data_q;
    dv_d    = dv_q;
    rdy_d   = rdy_q;
    start   = 1'b0;
    if (ena) begin
      dv_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          rdy_d = 1'b1;
          if (bus.smp_valid && rdy_q) begin
            start   = 1'b1;
            base_d  = base_inc;
            rdy_d   = 1'b0;
            state_d = MUL;
          end
        end
        MUL: begin
          if (mul_done) state_d = OUT;
        end
        OUT: begin
          data_d  = res;
          dv_d    = 1'b1;
          hcnt_d  = '0;
          state_d = HOLD;
        end
        HOLD: begin
          if (hcnt_q == HLAST) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      base_q  <= base_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.smp_ready = rdy_q;
  assign bus.out_data  = data_q;
  assign bus.out_dv    = dv_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fm_inc_word_gen.sv
// Self-checking bench for fm_inc_word_gen: vector table plus scoreboard.
// Define SATURATE_EN for both bench and RTL to test the clamping build.
module tb_fm_inc_word_gen;
  import fm_pkg::*;

  localparam int SW  = 8;
  localparam int KW  = 8;
  localparam int DW  = 24;
  localparam int HC  = 4;
  localparam int LAT = KW + 2;
  localparam int PER = KW + 2 + HC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [DW-1:0] base_inc = '0;
  logic [KW-1:0] dev_gain = '0;
  logic          busy;

  fm_inc_word_gen_if #(.SW(SW), .DW(DW)) bus ();

  fm_inc_word_gen #(
    .SW       (SW),
    .KW       (KW),
    .DW       (DW),
    .HOLD_CYC (HC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .base_inc (base_inc),
    .dev_gain (dev_gain),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int act = 0;
  int n_acc = 0;
  int n_dv = 0;
  int acc_cyc = 0;
  int dv_cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            stamp_q[$];
  logic [DW-1:0] last_data;
  bit            last_ok = 0;
  logic [DW-1:0] e_m;
  int            s_m;

  typedef struct {
    logic [DW-1:0] base;
    logic [KW-1:0] gain;
    logic [SW-1:0] smp;
    logic [DW-1:0] exp_wrap;
    logic [DW-1:0] exp_sat;
  } vec_t;

  vec_t vt[9];

  function automatic logic [DW-1:0] model(
    logic [DW-1:0] b, logic [KW-1:0] g, logic signed [SW-1:0] s);
    longint p;
    longint sm;
    p  = longint'(s) * longint'(g);
    sm = longint'(b) + p;
`ifdef SATURATE_EN
    if (sm < 0) return '0;
    if (sm > longint'(24'hFFFFFF)) return '1;
`endif
    return sm[DW-1:0];
  endfunction

  task automatic check(string nm, logic [63:0] a, logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endtask

  // Scoreboard monitor: samples pre-edge values at every rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stamp_q.delete();
      last_ok = 0;
    end else begin
      if (bus.out_dv) begin
        if (ena) begin
          n_dv++;
          dv_cyc = cyc;
          nchk++;
          if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL sb_empty: dv pulse with data %0h, no sample pending",
                     bus.out_data);
          end else begin
            e_m = exp_q.pop_front();
            s_m = stamp_q.pop_front();
            check("sb_data", bus.out_data, e_m);
            check("sb_latency", act - s_m, LAT);
          end
        end
        last_data = bus.out_data;
        last_ok   = 1;
      end else if (last_ok) begin
        check("hold_stable", bus.out_data, last_data);
      end else begin
        last_data = bus.out_data;
        last_ok   = 1;
      end
      if (ena && bus.smp_valid && bus.smp_ready) begin
        n_acc++;
        acc_cyc = cyc;
        exp_q.push_back(model(base_inc, dev_gain, bus.smp_data));
        stamp_q.push_back(act);
      end
      if (ena) act++;
    end
    cyc++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(logic [DW-1:0] b, logic [KW-1:0] g,
                       logic [SW-1:0] s);
    int st;
    bit ok;
    st = n_acc;
    ok = 0;
    base_inc      = b;
    dev_gain      = g;
    bus.smp_data  = s;
    bus.smp_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (n_acc != st) begin
        ok = 1;
        break;
      end
    end
    bus.smp_valid = 1'b0;
    base_inc      = DW'($urandom);
    dev_gain      = KW'($urandom);
    bus.smp_data  = SW'($urandom);
    if (!ok) begin
      nchk++;
      nfail++;
      $display("FAIL accept_timeout: sample %0h not accepted", s);
    end
  endtask

  task automatic wait_dv();
    int st;
    bit ok;
    st = n_dv;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (n_dv != st) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      nchk++;
      nfail++;
      $display("FAIL dv_timeout: no out_dv within 60 cycles");
    end
  endtask

  initial begin
    int t[3];
    int c0;
    int nd;
    int got;
    bit seen;
    logic [SW-1:0] smps[3];
    logic [DW-1:0] ev;

    vt[0] = '{24'h100000, 8'h10, 8'h7F, 24'h1007F0, 24'h1007F0};
    vt[1] = '{24'h100000, 8'h10, 8'h80, 24'h0FF800, 24'h0FF800};
    vt[2] = '{24'h000010, 8'h20, 8'hFF, 24'hFFFFF0, 24'h000000};
    vt[3] = '{24'hFFFFFF, 8'h01, 8'h01, 24'h000000, 24'hFFFFFF};
    vt[4] = '{24'h000000, 8'hFF, 8'h80, 24'hFF8080, 24'h000000};
    vt[5] = '{24'h123456, 8'h00, 8'h55, 24'h123456, 24'h123456};
    vt[6] = '{24'h800000, 8'hFF, 8'h7F, 24'h807E81, 24'h807E81};
    vt[7] = '{24'h400000, 8'hFF, 8'h80, 24'h3F8080, 24'h3F8080};
    vt[8] = '{24'h000100, 8'h03, 8'hFE, 24'h0000FA, 24'h0000FA};

    bus.smp_data  = '0;
    bus.smp_valid = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_dv", bus.out_dv, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.smp_ready, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", bus.smp_ready, 1);
    check("idle_busy", busy, 0);

    // Cycle-by-cycle timeline of one positive sample.
    offer(24'h100000, 8'h10, 8'h7F);
    for (int k = 1; k <= PER; k++) begin
      tick();
      check($sformatf("tl_dv_%0d", k), bus.out_dv, (k == LAT - 1));
      check($sformatf("tl_ready_%0d", k), bus.smp_ready, (k >= PER - 1));
      check($sformatf("tl_busy_%0d", k), busy, (k < PER - 1));
    end
    check("tl_data", bus.out_data, 24'h1007F0);

    for (int i = 0; i < 9; i++) begin
`ifdef SATURATE_EN
      ev = vt[i].exp_sat;
`else
      ev = vt[i].exp_wrap;
`endif
      offer(vt[i].base, vt[i].gain, vt[i].smp);
      wait_dv();
      check($sformatf("vec%0d_data", i), bus.out_data, ev);
    end

    // Back-to-back: valid held high, new sample after each accept.
    smps[0] = 8'h11;
    smps[1] = 8'hA2;
    smps[2] = 8'h33;
    base_inc      = 24'h0A0000;
    dev_gain      = 8'h5C;
    bus.smp_data  = smps[0];
    bus.smp_valid = 1'b1;
    c0  = n_acc;
    got = 0;
    for (int i = 0; i < 100 && got < 3; i++) begin
      tick();
      if (n_acc != c0 + got) begin
        t[got] = acc_cyc;
        got++;
        if (got < 3) bus.smp_data = smps[got];
      end
    end
    bus.smp_valid = 1'b0;
    check("b2b_accepts", got, 3);
    if (got == 3) begin
      check("b2b_period1", t[1] - t[0], PER);
      check("b2b_period2", t[2] - t[1], PER);
    end
    wait_dv();
    check("b2b_last", bus.out_data, model(24'h0A0000, 8'h5C, 8'h33));

    // ena dropped for 5 cycles in the middle of MUL.
    offer(24'h200000, 8'h07, 8'hF3);
    c0 = acc_cyc;
    tick(3);
    ena = 1'b0;
    tick(5);
    ena = 1'b1;
    wait_dv();
    check("ena_delay", dv_cyc - c0, LAT + 5);
    check("ena_data", bus.out_data, 24'h1FFFA5);

    // ena dropped while the dv pulse is high.
    offer(24'h000500, 8'h02, 8'h04);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_dv) begin
        seen = 1;
        break;
      end
    end
    check("dvhold_seen", seen, 1);
    nd  = n_dv;
    ena = 1'b0;
    tick(3);
    check("dvhold_frozen", bus.out_dv, 1);
    check("dvhold_busy", busy, 1);
    ena = 1'b1;
    tick();
    check("dvhold_release", bus.out_dv, 0);
    check("dvhold_once", n_dv - nd, 1);
    check("dvhold_data", bus.out_data, 24'h000508);

    // Reset while the multiplier is at bit 3.
    offer(24'h111111, 8'hFF, 8'h80);
    tick(3);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    nd = n_dv;
    tick(20);
    check("rstmid_no_dv", n_dv, nd);
    check("rstmid_data", bus.out_data, 0);
    check("rstmid_busy", busy, 0);
    offer(24'h000800, 8'h81, 8'h7F);
    wait_dv();
    check("rstmid_next", bus.out_data, 24'h0047FF);

    tick(2);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
